// File: rtl/vram_fast_sync.sv
// Dual-port video RAM: one read/write port, one read-only port.
// Configurable read latency, collision policy and post-reset clear.
module vram_fast_sync #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1,
  parameter int CLEAR_EN     = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE_A,
  input  logic              WE_A,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [DATA_W-1:0] WDATA_A,
  output logic [DATA_W-1:0] RDATA_A,
  output logic              RVALID_A,
  input  logic              CE_B,
  input  logic [ADDR_W-1:0] ADDR_B,
  output logic [DATA_W-1:0] RDATA_B,
  output logic              RVALID_B,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_lat
    $error("vram_fast_sync: READ_LATENCY must be 1..3");
  end

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic live;
  logic addr_ok;
  logic wr_a;
  logic rd_a;
  logic rd_b;
  logic clr_we;
  logic [DATA_W-1:0] src_b;

`ifdef SYNTHESIS
  assign addr_ok = 1'b1;
`else
  assign addr_ok = !$isunknown(ADDR_A);
`endif

  assign live   = !RESET && (state == ST_IDLE);
  assign wr_a   = live && CE_A && WE_A && addr_ok;
  assign rd_a   = live && CE_A && !WE_A;
  assign rd_b   = live && CE_B;
  assign clr_we = !RESET && (state == ST_CLEAR);
  assign BUSY   = (state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_RST;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_RST: begin
          cnt   <= '0;
          state <= (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (clr_we) mem[cnt] <= CLEAR_VAL;
    else if (wr_a) mem[ADDR_A] <= WDATA_A;
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (live && CE_A && WE_A && !addr_ok)
      $display("vram_fast_sync: write with unknown ADDR_A ignored");
  end
`endif

  // Same-address write on A shows through to B only in write-first mode.
  assign src_b = (WRITE_FIRST != 0 && wr_a && ADDR_A == ADDR_B)
               ? WDATA_A : mem[ADDR_B];

  logic [READ_LATENCY-1:0] pa_v;
  logic [READ_LATENCY-1:0] pb_v;
  logic [DATA_W-1:0]       pa_d [READ_LATENCY];
  logic [DATA_W-1:0]       pb_d [READ_LATENCY];

  // Stages load only behind a valid, so the last stage holds its data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pa_v <= '0;
      pb_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pa_d[i] <= '0;
        pb_d[i] <= '0;
      end
    end else begin
      pa_v[0] <= rd_a;
      pb_v[0] <= rd_b;
      if (rd_a) pa_d[0] <= mem[ADDR_A];
      if (rd_b) pb_d[0] <= src_b;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pa_v[i] <= pa_v[i-1];
        pb_v[i] <= pb_v[i-1];
        if (pa_v[i-1]) pa_d[i] <= pa_d[i-1];
        if (pb_v[i-1]) pb_d[i] <= pb_d[i-1];
      end
    end
  end

  assign RDATA_A  = pa_d[READ_LATENCY-1];
  assign RVALID_A = pa_v[READ_LATENCY-1];
  assign RDATA_B  = pb_d[READ_LATENCY-1];
  assign RVALID_B = pb_v[READ_LATENCY-1];

endmodule

// File: tb/tb_vram_fast_sync.sv
// Directed bench for vram_fast_sync across latency,
// collision-policy, clear-value and clear-enable variants.
module tb_vram_fast_sync;

  logic        CLK;
  logic        RESET;
  logic        CE_A;
  logic        WE_A;
  logic [10:0] ADDR_A;
  logic [7:0]  WDATA_A;
  logic        CE_B;
  logic [10:0] ADDR_B;

  logic [7:0] ra1, rb1, ra2, rb2, ra3, rb3, ra4, rb4;
  logic       va1, vb1, va2, vb2, va3, vb3, va4, vb4;
  logic       bz1, bz2, bz3, bz4;

  int n_chk;
  int n_fail;

  vram_fast_sync u_d1 (
    .CLK(CLK), .RESET(RESET),
    .CE_A(CE_A), .WE_A(WE_A), .ADDR_A(ADDR_A),
    .WDATA_A(WDATA_A), .RDATA_A(ra1), .RVALID_A(va1),
    .CE_B(CE_B), .ADDR_B(ADDR_B),
    .RDATA_B(rb1), .RVALID_B(vb1), .BUSY(bz1)
  );

  vram_fast_sync #(
    .READ_LATENCY(2), .WRITE_FIRST(0)
  ) u_d2 (
    .CLK(CLK), .RESET(RESET),
    .CE_A(CE_A), .WE_A(WE_A), .ADDR_A(ADDR_A),
    .WDATA_A(WDATA_A), .RDATA_A(ra2), .RVALID_A(va2),
    .CE_B(CE_B), .ADDR_B(ADDR_B),
    .RDATA_B(rb2), .RVALID_B(vb2), .BUSY(bz2)
  );

  vram_fast_sync #(
    .READ_LATENCY(3), .CLEAR_VAL(8'h5A)
  ) u_d3 (
    .CLK(CLK), .RESET(RESET),
    .CE_A(CE_A), .WE_A(WE_A), .ADDR_A(ADDR_A),
    .WDATA_A(WDATA_A), .RDATA_A(ra3), .RVALID_A(va3),
    .CE_B(CE_B), .ADDR_B(ADDR_B),
    .RDATA_B(rb3), .RVALID_B(vb3), .BUSY(bz3)
  );

  vram_fast_sync #(
    .ADDR_W(4), .CLEAR_EN(0)
  ) u_d4 (
    .CLK(CLK), .RESET(RESET),
    .CE_A(CE_A), .WE_A(WE_A), .ADDR_A(ADDR_A[3:0]),
    .WDATA_A(WDATA_A), .RDATA_A(ra4), .RVALID_A(va4),
    .CE_B(CE_B), .ADDR_B(ADDR_B[3:0]),
    .RDATA_B(rb4), .RVALID_B(vb4), .BUSY(bz4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    CE_A = 1'b0;
    WE_A = 1'b0;
    CE_B = 1'b0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [7:0] d);
    CE_A = 1'b1; WE_A = 1'b1; ADDR_A = a; WDATA_A = d;
  endtask

  task automatic rda(input logic [10:0] a);
    CE_A = 1'b1; WE_A = 1'b0; ADDR_A = a;
  endtask

  task automatic rdb(input logic [10:0] a);
    CE_B = 1'b1; ADDR_B = a;
  endtask

  logic       any_v;
  logic [10:0] clr_addr [4];
  logic [7:0]  pipe_val [3];

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    RESET   = 1'b1;
    ADDR_A  = '0;
    ADDR_B  = '0;
    WDATA_A = '0;
    idle();
    repeat (3) tick();

    chk("rst_busy",  bz1, 1);
    chk("rst_a",     {va1, ra1}, 9'h000);
    chk("rst_b",     {vb1, rb1}, 9'h000);
    chk("rst_busy4", bz4, 1);

    // Clear: requests during busy must vanish.
    RESET = 1'b0;
    any_v = 1'b0;
    for (int e = 1; e <= 2049; e++) begin
      idle();
      if (e == 5 || e == 6) wr(11'h200, 8'h77);
      else if (e == 7 || e == 2049) rda(11'h200);
      tick();
      any_v |= va1 | va2 | va3;
      if (e == 1) chk("noclr_busy", bz4, 0);
      if (e == 2048) chk("clr_busy_2048", {bz1, bz2, bz3}, 3'b111);
      if (e == 2049) chk("clr_busy_2049", {bz1, bz2, bz3}, 3'b000);
    end
    idle();
    repeat (2) begin
      tick();
      any_v |= va1 | va2 | va3;
    end
    chk("busy_drop", any_v, 0);

    clr_addr[0] = 11'h000;
    clr_addr[1] = 11'h3FF;
    clr_addr[2] = 11'h7FF;
    clr_addr[3] = 11'h200;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 4) rda(clr_addr[k]);
      tick();
      if (k < 4) chk("clr_rd_d1", {va1, ra1}, 9'h100);
      if (k >= 2) chk("clr_rd_d3", {va3, ra3}, 9'h15A);
    end

    // Latency sweep on port A.
    idle(); wr(11'h123, 8'hA5); tick();
    idle(); rda(11'h123); tick();
    idle();
    chk("lat_v0", {va1, va2, va3}, 3'b100);
    chk("lat_d1", ra1, 8'hA5);
    tick();
    chk("lat_v1", {va1, va2, va3}, 3'b010);
    chk("lat_d2", ra2, 8'hA5);
    tick();
    chk("lat_v2", {va1, va2, va3}, 3'b001);
    chk("lat_d3", ra3, 8'hA5);
    tick();
    chk("lat_v3", {va1, va2, va3}, 3'b000);
    chk("lat_hold", ra1, 8'hA5);

    // Pipelined port B reads.
    pipe_val[0] = 8'h11;
    pipe_val[1] = 8'h22;
    pipe_val[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      idle(); wr(11'h010 + 11'(k), pipe_val[k]); tick();
    end
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 3) rdb(11'h010 + 11'(k));
      tick();
      if (k < 3)
        chk("pipe_d1", {vb1, rb1}, {1'b1, pipe_val[k]});
      if (k == 3) chk("pipe_d1_hold", {vb1, rb1}, 9'h033);
      if (k >= 2 && k < 5)
        chk("pipe_d3", {vb3, rb3}, {1'b1, pipe_val[k-2]});
      if (k == 5) chk("pipe_d3_hold", {vb3, rb3}, 9'h033);
    end

    // Collision on 0x050, then a non-colliding pair.
    idle(); wr(11'h050, 8'h0F); tick();
    idle(); wr(11'h050, 8'hF0); rdb(11'h050); tick();
    chk("col_d1", {vb1, rb1}, 9'h1F0);
    idle(); wr(11'h051, 8'hAA); rdb(11'h050); tick();
    chk("col_d1_next", {vb1, rb1}, 9'h1F0);
    chk("col_d2_old", {vb2, rb2}, 9'h10F);
    idle(); tick();
    chk("col_d2_next", {vb2, rb2}, 9'h1F0);
    chk("col_d3", {vb3, rb3}, 9'h1F0);
    tick();
    chk("col_d3_next", {vb3, rb3}, 9'h1F0);
    idle(); rda(11'h051); tick();
    idle();
    chk("noncol_d1", {va1, ra1}, 9'h1AA);

    // Reset while a latency-3 read is in flight, then mid-clear.
    tick();
    idle(); rdb(11'h050); tick();
    idle();
    any_v = vb3;
    RESET = 1'b1;
    repeat (3) begin
      tick();
      any_v |= vb3;
    end
    chk("flush_rb3", rb3, 8'h00);
    RESET = 1'b0;
    for (int e = 1; e <= 1001; e++) begin
      tick();
      any_v |= vb3;
    end
    chk("mid_busy", bz1, 1);
    RESET = 1'b1;
    repeat (2) begin
      tick();
      any_v |= vb3;
    end
    RESET = 1'b0;
    for (int e = 1; e <= 2049; e++) begin
      tick();
      any_v |= vb3;
      if (e == 1) chk("re_noclr_busy", bz4, 0);
      if (e == 2048) chk("re_busy_2048", {bz1, bz3}, 2'b11);
      if (e == 2049) chk("re_busy_2049", {bz1, bz3}, 2'b00);
    end
    chk("flush_novalid", any_v, 0);

    idle(); rda(11'h050); tick();
    idle();
    chk("reclr_d1", {va1, ra1}, 9'h100);
    tick();
    tick();
    chk("reclr_d3", {va3, ra3}, 9'h15A);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
